microwave_timer: RTL and testbench

Countdown timer stage of the microwave datapath, sitting beside `control`. It captures cook time from keypad digits, counts it down once per second while `control` drives `mag_on`, and returns `timer_done` to `control` to stop the magnetron. BCD digit outputs feed the display stage directly.

---
 rtl/microwave_timer.sv | 188 ++++++++++++++++++
 tb/tb_microwave_timer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/microwave_timer.sv
// microwave_timer
//   Countdown stage of the microwave datapath. Captures MM:SS cook time from
//   keypad digits. Counts down once per second while mag_on is high. Raises
//   timer_done so that control can stop the magnetron.
//
// Parameters
//   TICKS_PER_SEC : clock cycles per countdown second (>= 2)
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous reset, active-high
//   clearn     in   active-low clear of the time and the done flag
//   mag_on     in   counting enable from control
//   key_valid  in   single-cycle strobe qualifying key_digit
//   key_digit  in   BCD keypad digit (values above 9 are ignored)
//   add30      in   single-cycle "+30 s" strobe
//   min_tens, min_ones, sec_tens, sec_ones  out  registered BCD time
//   zero       out  combinational, all four digits are 0
//   timer_done out  registered done level to control
//
// Configuration
//   TIMER_ADD30_EN : when defined, add30 adds 30 s (saturating at 99:59).
//                    When undefined, add30 is ignored and no add logic exists.

module microwave_timer #(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clearn,
    input  logic       mag_on,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       add30,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       zero,
    output logic       timer_done
);

    localparam int             PW     = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0]  PS_MAX = PW'(TICKS_PER_SEC - 1);

    logic [PW-1:0] presc, presc_next;
    logic [3:0]    mt_next, mo_next, st_next, so_next;
    logic          done_next;
    logic          tick, accept;
    logic [3:0]    d_mt, d_mo, d_st, d_so;   // time minus one second
    logic          dec_zero;

    assign zero = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                  (sec_tens == 4'd0) && (sec_ones == 4'd0);

`ifdef TIMER_ADD30_EN
    logic [3:0] a_mt, a_mo, a_st, a_so;      // time plus thirty seconds

    always_comb begin
        a_mt = min_tens;
        a_mo = min_ones;
        a_st = sec_tens;
        a_so = sec_ones;
        if (sec_tens >= 4'd3) begin
            // Carry into minutes; at 99 minutes the result pins to 99:59.
            a_st = sec_tens - 4'd3;
            if (min_tens == 4'd9 && min_ones == 4'd9) begin
                a_st = 4'd5;
                a_so = 4'd9;
            end else if (min_ones == 4'd9) begin
                a_mo = 4'd0;
                a_mt = min_tens + 4'd1;
            end else begin
                a_mo = min_ones + 4'd1;
            end
        end else begin
            a_st = sec_tens + 4'd3;
        end
    end
`else
    logic unused_add30;
    assign unused_add30 = add30;
`endif

    // BCD borrow chain; only used when the time is non-zero, so the
    // min_tens underflow case never reaches the registers.
    always_comb begin
        d_mt = min_tens;
        d_mo = min_ones;
        d_st = sec_tens;
        d_so = sec_ones;
        if (sec_ones != 4'd0) begin
            d_so = sec_ones - 4'd1;
        end else begin
            d_so = 4'd9;
            if (sec_tens != 4'd0) begin
                d_st = sec_tens - 4'd1;
            end else begin
                d_st = 4'd5;
                if (min_ones != 4'd0) begin
                    d_mo = min_ones - 4'd1;
                end else begin
                    d_mo = 4'd9;
                    d_mt = min_tens - 4'd1;
                end
            end
        end
        dec_zero = (d_mt == 4'd0) && (d_mo == 4'd0) &&
                   (d_st == 4'd0) && (d_so == 4'd0);
    end

    // NOTE: every signal driven here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        mt_next    = min_tens;
        mo_next    = min_ones;
        st_next    = sec_tens;
        so_next    = sec_ones;
        done_next  = timer_done;
        presc_next = presc;
        tick       = mag_on && (presc == PS_MAX) && !zero;
        accept     = key_valid && (key_digit <= 4'd9) && !mag_on;

        if (!clearn) begin
            mt_next    = 4'd0;
            mo_next    = 4'd0;
            st_next    = 4'd0;
            so_next    = 4'd0;
            done_next  = 1'b0;
            presc_next = '0;
        end else begin
            // Prescaler runs whenever mag_on is high, even when add30 steals
            // the tick, so the second boundary stays put.
            if (mag_on) begin
                presc_next = (presc == PS_MAX) ? '0 : presc + 1'b1;
            end

            if (accept) begin
                mt_next   = min_ones;
                mo_next   = sec_tens;
                st_next   = sec_ones;
                so_next   = key_digit;
                done_next = 1'b0;
`ifdef TIMER_ADD30_EN
            end else if (add30) begin
                mt_next   = a_mt;
                mo_next   = a_mo;
                st_next   = a_st;
                so_next   = a_so;
                done_next = 1'b0;
`endif
            end else if (mag_on) begin
                if (zero) begin
                    done_next = 1'b1;
                end else if (tick) begin
                    mt_next = d_mt;
                    mo_next = d_mo;
                    st_next = d_st;
                    so_next = d_so;
                    if (dec_zero) begin
                        done_next = 1'b1;
                    end
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the values from before this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            min_tens   <= 4'd0;
            min_ones   <= 4'd0;
            sec_tens   <= 4'd0;
            sec_ones   <= 4'd0;
            timer_done <= 1'b0;
            presc      <= '0;
        end else begin
            min_tens   <= mt_next;
            min_ones   <= mo_next;
            sec_tens   <= st_next;
            sec_ones   <= so_next;
            timer_done <= done_next;
            presc      <= presc_next;
        end
    end

endmodule

// File: tb/tb_microwave_timer.sv
module tb_microwave_timer;

    localparam int TPS = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clearn = 1'b1;
    logic       mag_on = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_digit = 4'd0;
    logic       add30 = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       zero, timer_done;

    always #5 clk = ~clk;

    microwave_timer #(.TICKS_PER_SEC(TPS)) dut (
        .clk        (clk),
        .rst        (rst),
        .clearn     (clearn),
        .mag_on     (mag_on),
        .key_valid  (key_valid),
        .key_digit  (key_digit),
        .add30      (add30),
        .min_tens   (min_tens),
        .min_ones   (min_ones),
        .sec_tens   (sec_tens),
        .sec_ones   (sec_ones),
        .zero       (zero),
        .timer_done (timer_done)
    );

    typedef struct {
        int unsigned cyc;      // edge number after which this state is due
        logic [15:0] digits;
        logic        zero;
        logic        done;
    } exp_t;

    exp_t        sb[$];
    int unsigned edge_cnt = 0;
    int          checks = 0;
    int          errors = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Reference model: minutes and seconds as plain integers, plus the
    // position inside the current second.
    int m_min = 0;
    int m_sec = 0;
    int m_ph  = 0;
    bit m_done = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %h expected %h", name, edge_cnt, act, exp);
        end
    endtask

    function automatic logic [15:0] model_digits();
        return {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10)};
    endfunction

    task automatic model_step(input logic r, input logic c, input logic m,
                              input logic kv, input logic [3:0] kd, input logic a);
        bit is_zero;
        bit tick;
        is_zero = (m_min == 0) && (m_sec == 0);
        if (r || !c) begin
            m_min = 0; m_sec = 0; m_ph = 0; m_done = 1'b0;
        end else begin
            tick = m && (m_ph == TPS - 1) && !is_zero;
            if (m) m_ph = (m_ph + 1) % TPS;
            if (kv && kd <= 4'd9 && !m) begin
                m_min  = (m_min % 10) * 10 + m_sec / 10;
                m_sec  = (m_sec % 10) * 10 + int'(kd);
                m_done = 1'b0;
`ifdef TIMER_ADD30_EN
            end else if (a) begin
                m_sec = m_sec + 30;
                if (m_sec >= 60) begin
                    if (m_min == 99) begin
                        m_sec = 59;
                    end else begin
                        m_sec = m_sec - 60;
                        m_min = m_min + 1;
                    end
                end
                m_done = 1'b0;
`endif
            end else if (m) begin
                if (is_zero) begin
                    m_done = 1'b1;
                end else if (tick) begin
                    if (m_sec > 0) m_sec = m_sec - 1;
                    else begin m_sec = 59; m_min = m_min - 1; end
                    if (m_min == 0 && m_sec == 0) m_done = 1'b1;
                end
            end
        end
    endtask

    // Drive one cycle of inputs and queue the state due after the next edge.
    task automatic step(input logic r, input logic c, input logic m,
                        input logic kv, input logic [3:0] kd, input logic a);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; clearn = c; mag_on = m; key_valid = kv; key_digit = kd; add30 = a;
        model_step(r, c, m, kv, kd, a);
        e.cyc    = edge_cnt + 1;
        e.digits = model_digits();
        e.zero   = (m_min == 0) && (m_sec == 0);
        e.done   = m_done;
        sb.push_back(e);
    endtask

    task automatic idle(input int n, input logic m);
        repeat (n) step(1'b0, 1'b1, m, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic key(input logic [3:0] d);
        step(1'b0, 1'b1, 1'b0, 1'b1, d, 1'b0);
    endtask

    task automatic clear();
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    // Monitor: compares each queued expectation once its edge has passed.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= edge_cnt) begin
                e = sb.pop_front();
                check("digits", {min_tens, min_ones, sec_tens, sec_ones}, e.digits);
                check("zero", {15'd0, zero}, {15'd0, e.zero});
                check("timer_done", {15'd0, timer_done}, {15'd0, e.done});
            end
        end
    end

    initial begin
        logic m_rand;
        int   wait_cnt;
        // Reset and hold
        step(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        idle(3, 1'b0);
        // Entry 01:30, count through the minute borrow to 00:59
        key(4'd1); key(4'd3); key(4'd0);
        idle(1, 1'b0);
        idle(TPS * 31 + 2, 1'b1);
        clear();
        // Done at 00:00, hold, then clear
        key(4'd2);
        idle(2 * TPS + 10, 1'b1);
        clear();
        // Pause keeps the partial second
        key(4'd5);
        idle(2, 1'b1);
        idle(10, 1'b0);
        idle(3, 1'b1);
        idle(2, 1'b0);
        clear();
        // Rejected digits
        key(4'hA);
        key(4'hF);
        key(4'd7);
        step(1'b0, 1'b1, 1'b1, 1'b1, 4'd3, 1'b0);
        idle(1, 1'b0);
        clear();
        // Start with no time entered
        idle(2, 1'b1);
        clear();
        // add30 cases
        key(4'd4); key(4'd5);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
        idle(1, 1'b0);
        key(4'd9); key(4'd9); key(4'd4); key(4'd5);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
        idle(1, 1'b0);
        clear();
        // add30 landing on a tick edge
        key(4'd1); key(4'd0);
        idle(TPS - 1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1);
        idle(TPS, 1'b1);
        clear();
        // Randomized traffic
        m_rand = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 19) == 0) m_rand = ~m_rand;
            step(($urandom_range(0, 199) == 0),
                 !($urandom_range(0, 79) == 0),
                 m_rand,
                 ($urandom_range(0, 4) == 0),
                 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 29) == 0));
        end
        idle(2, 1'b0);
        // Drain the scoreboard with a bounded wait
        wait_cnt = 0;
        while (sb.size() > 0 && wait_cnt < 10) begin
            @(negedge clk);
            wait_cnt++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
